// File: rtl/hls_channel_fifo.sv
// Responder end of an HLS channel: a circular-buffer FIFO with registered pop data.
// Push/pop handshakes are qualified by ready flags derived from the registered occupancy.
module hls_channel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       write_valid,
  output logic                       write_ready,
  input  logic                       read_valid,
  output logic                       read_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] out_q;
  logic             push, pop;

  assign write_ready = (count_q != CW'(DEPTH));
  assign read_ready  = (count_q != '0);
  assign push        = write_valid && write_ready;
  assign pop         = read_valid && read_ready;
  assign out_data    = out_q;
  assign count       = count_q;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (push) wp_d = (wp_q == AW'(DEPTH-1)) ? '0 : wp_q + 1'b1;
    if (pop)  rp_d = (rp_q == AW'(DEPTH-1)) ? '0 : rp_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is never reset; pointers and count alone decide what is readable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      out_q   <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      if (pop) out_q <= mem_q[rp_q];
    end
  end

endmodule
